// File: rtl/chacha_scheduler.sv
// ChaCha20 job scheduler: per-channel context store, round-robin job grant,
// core context load, keystream forwarding and block-counter write-back.
module chacha_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_write,
  input  logic [CH_W+3:0]      cfg_address,
  input  logic [31:0]          cfg_writedata,
  input  logic [NUM_CH-1:0]    req_valid,
  input  logic [NUM_CH*32-1:0] req_blocks,
  output logic [NUM_CH-1:0]    req_ack,
  output logic                 core_write,
  output logic                 core_read,
  output logic [4:0]           core_address,
  output logic [31:0]          core_writedata,
  input  logic [31:0]          core_readdata,
  input  logic [511:0]         core_st_data,
  input  logic                 core_st_valid,
  output logic                 core_st_ready,
  output logic [511:0]         out_data,
  output logic [CH_W-1:0]      out_channel,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_STREAM  = 3'd3,
    S_SAVE    = 3'd4,
    S_CAPTURE = 3'd5
  } state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_ptr;
  logic [CH_W-1:0]   r_ch;
  logic [3:0]        r_word;
  logic [31:0]       r_left;
  logic              r_core_write;
  logic              r_core_read;
  logic [4:0]        r_core_addr;
  logic [31:0]       r_core_wdata;
  logic [31:0]       r_ctx [NUM_CH*16];

  logic              w_any;
  logic [CH_W-1:0]   w_gnt_ch;
  logic [CH_W-1:0]   w_idx;
  logic [31:0]       w_gnt_blocks;
  logic              w_stream;
  logic              w_xfer;

  // Round-robin search: scan downwards so the channel closest to r_ptr wins.
  always_comb begin
    w_any        = 1'b0;
    w_gnt_ch     = '0;
    w_idx        = '0;
    w_gnt_blocks = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_idx = r_ptr + CH_W'(i);
      if (req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_gnt_ch = w_idx;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt_ch == CH_W'(i)) w_gnt_blocks = req_blocks[i*32 +: 32];
    end
  end

  // Handshakes: a stream beat moves on an edge where valid and ready are both
  // high, and the source holds valid/data until then; req_valid is held until
  // its one-cycle req_ack, which is issued in the IDLE cycle that grants it.
  assign w_stream      = (r_state == S_STREAM);
  assign w_xfer        = w_stream && core_st_valid && out_ready;
  assign core_st_ready = w_stream && out_ready;
  assign out_valid     = w_stream && core_st_valid;
  assign out_last      = out_valid && (r_left == 32'd1);
  assign out_data      = w_stream ? core_st_data : '0;
  assign out_channel   = w_stream ? r_ch : '0;
  assign req_ack       = (r_state == S_IDLE && w_any && !reset) ?
                         (NUM_CH'(1) << w_gnt_ch) : '0;

  assign core_write     = r_core_write;
  assign core_read      = r_core_read;
  assign core_address   = r_core_addr;
  assign core_writedata = r_core_wdata;
  assign busy           = (r_state != S_IDLE);
  assign dbg_state      = r_state;

  // Core strobes are set on the transition into the state that owns them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_ch         <= '0;
      r_word       <= '0;
      r_left       <= '0;
      r_core_write <= 1'b0;
      r_core_read  <= 1'b0;
      r_core_addr  <= '0;
      r_core_wdata <= '0;
      for (int i = 0; i < NUM_CH*16; i++) r_ctx[i] <= '0;
    end else begin
      if (cfg_write) r_ctx[cfg_address] <= cfg_writedata;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ptr  <= w_gnt_ch + CH_W'(1);
            r_ch   <= w_gnt_ch;
            r_left <= w_gnt_blocks;
            if (w_gnt_blocks != 32'd0) begin
              r_state      <= S_LOAD;
              r_word       <= 4'd0;
              r_core_write <= 1'b1;
              r_core_addr  <= 5'd0;
              r_core_wdata <= r_ctx[{w_gnt_ch, 4'd0}];
            end
          end
        end
        S_LOAD: begin
          if (r_word == 4'd15) begin
            r_state      <= S_START;
            r_core_addr  <= 5'd16;
            r_core_wdata <= r_left;
          end else begin
            r_word       <= r_word + 4'd1;
            r_core_addr  <= {1'b0, r_word + 4'd1};
            r_core_wdata <= r_ctx[{r_ch, r_word + 4'd1}];
          end
        end
        S_START: begin
          r_state      <= S_STREAM;
          r_core_write <= 1'b0;
          r_core_addr  <= '0;
          r_core_wdata <= '0;
        end
        S_STREAM: begin
          if (w_xfer) begin
            r_left <= r_left - 32'd1;
            if (r_left == 32'd1) begin
              r_state     <= S_SAVE;
              r_core_read <= 1'b1;
              r_core_addr <= 5'd12;
            end
          end
        end
        S_SAVE: begin
          r_state     <= S_CAPTURE;
          r_core_read <= 1'b0;
          r_core_addr <= '0;
        end
        S_CAPTURE: begin
          // Placed after the cfg write so the returned counter wins a collision.
          r_ctx[{r_ch, 4'd12}] <= core_readdata;
          r_state              <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/chacha_scheduler.md
CHACHA_SCHEDULER -- requirements
Module: chacha_scheduler

Interface
REQ-001 Parameter: NUM_CH, default 4, number of requester channels, power of two, 2..8.
REQ-002 Parameter: CH_W, default $clog2(NUM_CH), channel index width.
REQ-003 clock  input  1  rising-edge clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_write  input  1  context write strobe.
REQ-006 cfg_address  input  CH_W+4  {channel, word}; word 0..15 = initial ChaCha20 state word.
REQ-007 cfg_writedata  input  32  context write data.
REQ-008 req_valid  input  NUM_CH  per-channel job request, held until acknowledged.
REQ-009 req_blocks  input  NUM_CH*32  per-channel 64-byte block count; channel i occupies bits [32i+31:32i].
REQ-010 req_ack  output  NUM_CH  one-cycle grant pulse per channel.
REQ-011 core_write, core_read  output  1 each  CSR master strobes to the ChaCha20 core.
REQ-012 core_address  output  5  core CSR address (0..15 init state, 16 pad counter).
REQ-013 core_writedata  output 32; core_readdata  input 32, valid exactly one cycle after core_read.
REQ-014 core_st_data  input 512; core_st_valid  input 1; core_st_ready  output 1: core keystream sink.
REQ-015 out_data  output 512; out_channel  output CH_W; out_valid  output 1; out_last  output 1; out_ready  input 1: keystream source.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 Context store SHALL hold 16 x 32-bit words per channel; cfg_write updates word cfg_address[3:0] of channel cfg_address[CH_W+3:4] on the next edge.
REQ-018 FSM states SHALL be IDLE, LOAD, START, STREAM, SAVE, CAPTURE.
REQ-019 IDLE: if any req_valid is high, grant one channel round-robin, starting with the channel after the last granted channel (channel 0 first after reset); pulse req_ack for that channel in the same cycle; latch the channel and its req_blocks.
REQ-020 A granted job with blocks == 0 SHALL return to IDLE with no core access.
REQ-021 LOAD: issue 16 consecutive core_write cycles, addresses 0..15, data = context words of the granted channel.
REQ-022 START: single core_write to address 16 with the latched block count, then enter STREAM.
REQ-023 STREAM: core_st_ready = out_ready; out_valid = core_st_valid; out_data = core_st_data; out_channel = granted channel; no combinational path other than these pass-throughs.
REQ-024 A transfer SHALL be counted when core_st_valid && out_ready; out_last SHALL be high with the transfer whose count equals the latched block count; after that transfer, enter SAVE.
REQ-025 Outside STREAM: core_st_ready = 0, out_valid = 0, out_last = 0.
REQ-026 SAVE: single core_read of address 12; CAPTURE: write core_readdata into context word 12 of the granted channel, then go to IDLE, so consecutive jobs continue the block counter.
REQ-027 A cfg_write to channel/word 12 in the same cycle as CAPTURE SHALL lose to CAPTURE; other cfg_writes to the active channel SHALL be accepted and take effect from the next job.
REQ-028 Block counter arithmetic SHALL be 32-bit, wrapping modulo 2^32 with no flag.
REQ-029 Never assert core_write and core_read together; at most one core access per cycle.
REQ-030 Requests dropped before grant SHALL be ignored; req_blocks is sampled only at the grant.

Reset
REQ-031 On reset: FSM to IDLE, round-robin pointer to channel 0, all context words to 0, all outputs 0; reset in mid-job SHALL abandon the job with no req_ack re-pulse.

Verification
REQ-032 Single job: channel 1, word 12 = 7, blocks = 3 -> 16 writes then write addr16 = 3; 3 transfers tagged channel 1, out_last on the 3rd; context[1][12] = 10.
REQ-033 Arbitration: all 4 channels request at once, blocks = 1 each -> grants in order 0,1,2,3; the next simultaneous request round starts at channel 0 after 3.
REQ-034 Backpressure: out_ready low 50 cycles mid-job -> no transfer lost or duplicated; block count exact.
REQ-035 Zero blocks: channel 2, blocks = 0 -> req_ack pulse, no core_write/core_read, busy for at most 1 cycle.
REQ-036 Wrap: word 12 = 0xFFFFFFFF, blocks = 2 -> context word 12 = 0x00000001 after the job.
REQ-037 Reset during STREAM -> outputs 0 next cycle; a new request after reset completes normally.
